store_write_unit: RTL and testbench

//  Write-side counterpart of the memory data register. Accepts store requests
//  (SB/SH/SW) from the datapath and drives them into data memory.

---
 rtl/store_write_unit.sv | 162 ++++++++++++++++
 tb/tb_store_write_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_unit.sv
// Store write unit: buffers SB/SH/SW stores in a FIFO, lane-places data, and
// issues them to data memory over a req/ack write handshake.
// Ports: clk, rst_n; st_valid/st_ready/st_addr/st_data/st_size/st_err (datapath);
// mem_req/mem_addr/mem_wdata/mem_be/mem_ack (memory); busy, count (status).
// Optional: define MISALIGN_TRAP_EN to drop misaligned stores and pulse st_err.
module store_write_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [AW-1:0]              st_addr,
  input  logic [31:0]                st_data,
  input  logic [1:0]                 st_size,
  output logic                       st_err,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  input  logic                       mem_ack,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-3:0] r_addr_q [DEPTH];
  logic [31:0]   r_data_q [DEPTH];
  logic [3:0]    r_be_q   [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_cnt_nxt;

  logic          w_full;
  logic          w_hs;
  logic          w_misal;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;

  assign w_full   = (r_count == CW'(DEPTH));
  assign st_ready = !w_full;
  assign w_hs     = st_valid && st_ready;

`ifdef MISALIGN_TRAP_EN
  logic r_err;

  assign w_misal = ((st_size == 2'b01) && st_addr[0]) ||
                   (st_size[1] && (st_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_hs && w_misal;
    end
  end

  assign st_err = r_err;
`else
  assign w_misal = 1'b0;
  assign st_err  = 1'b0;
`endif

  // Misaligned stores still complete the handshake but never enter the FIFO.
  assign w_push = w_hs && !w_misal;
  assign w_pop  = (r_state == S_REQ) && mem_ack;

  always_comb begin
    w_wdata = st_data;
    w_be    = 4'b1111;
    case (st_size)
      2'b00: begin
        w_wdata = {4{st_data[7:0]}};
        w_be    = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{st_data[15:0]}};
        w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = st_data;
        w_be    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_wptr] <= st_addr[AW-1:2];
      r_data_q[r_wptr] <= w_wdata;
      r_be_q[r_wptr]   <= w_be;
    end
  end

  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stay in REQ across pops while entries remain, giving 1 write/cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_pop && (w_cnt_nxt == '0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (r_state == S_REQ) begin
      mem_req   = 1'b1;
      mem_addr  = {r_addr_q[r_rptr], 2'b00};
      mem_wdata = r_data_q[r_rptr];
      mem_be    = r_be_q[r_rptr];
    end
  end

  assign busy  = (r_count != '0) || mem_req;
  assign count = r_count;

endmodule

// File: tb/tb_store_write_unit.sv
// Directed self-checking bench for store_write_unit (DEPTH=4, AW=32).
// Compile with +define+MISALIGN_TRAP_EN to exercise the trap variant.
module tb_store_write_unit;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        busy;
  logic [2:0]  count;

  int n_chk;
  int n_err;

  store_write_unit #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    mem_ack  = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #12;
    check("rst_ready", st_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_be", mem_be, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_err", st_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single SW with ack tied high
    mem_ack = 1'b1;
    drive(1'b1, 32'h100, 32'hDEADBEEF, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    check("t1_cnt_after_push", count, 1);
    check("t1_no_req_yet", mem_req, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_wdata", mem_wdata, 32'hDEADBEEF);
    check("t1_be", mem_be, 4'b1111);
    tick();
    check("t1_idle_req", mem_req, 0);
    check("t1_idle_cnt", count, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_addr", mem_addr, 0);

    // 2: SB and SH lane placement
    mem_ack = 1'b0;
    drive(1'b1, 32'h203, 32'h0000005A, 2'b00);
    tick();
    drive(1'b1, 32'h202, 32'h00001234, 2'b01);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    check("t2_req", mem_req, 1);
    check("t2_cnt", count, 2);
    check("t2_sb_addr", mem_addr, 32'h200);
    check("t2_sb_wdata", mem_wdata, 32'h5A5A5A5A);
    check("t2_sb_be", mem_be, 4'b1000);
    mem_ack = 1'b1;
    tick();
    check("t2_sh_req", mem_req, 1);
    check("t2_sh_addr", mem_addr, 32'h200);
    check("t2_sh_wdata", mem_wdata, 32'h12341234);
    check("t2_sh_be", mem_be, 4'b1100);
    check("t2_sh_cnt", count, 1);
    tick();
    mem_ack = 1'b0;
    check("t2_idle_req", mem_req, 0);
    check("t2_idle_cnt", count, 0);

    // 3: fill with ack low, 5th push ignored, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
      tick();
    end
    check("t3_full_cnt", count, 4);
    check("t3_full_ready", st_ready, 0);
    drive(1'b1, 32'h400, 32'hBAD, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    check("t3_5th_cnt", count, 4);
    check("t3_5th_ready", st_ready, 0);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_req", mem_req, 1);
      check("t3_drain_addr", mem_addr, 32'h300 + 32'(4 * i));
      check("t3_drain_wdata", mem_wdata, 32'hA0 + 32'(i));
      check("t3_drain_cnt", count, 32'(4 - i));
      tick();
    end
    mem_ack = 1'b0;
    check("t3_end_req", mem_req, 0);
    check("t3_end_cnt", count, 0);
    check("t3_end_ready", st_ready, 1);

    // 4: ack delayed 3 cycles, outputs held stable
    drive(1'b1, 32'h500, 32'h55, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_req", mem_req, 1);
      check("t4_hold_addr", mem_addr, 32'h500);
      check("t4_hold_wdata", mem_wdata, 32'h55);
      check("t4_hold_be", mem_be, 4'b1111);
      check("t4_hold_cnt", count, 1);
      tick();
    end
    mem_ack = 1'b1;
    check("t4_ack_req", mem_req, 1);
    check("t4_ack_addr", mem_addr, 32'h500);
    tick();
    mem_ack = 1'b0;
    check("t4_done_req", mem_req, 0);
    check("t4_done_cnt", count, 0);

    // 5: async reset with 3 queued and a request outstanding
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i), 32'h60 + 32'(i), 2'b10);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    check("t5_pre_req", mem_req, 1);
    check("t5_pre_cnt", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_req", mem_req, 0);
    check("t5_rst_cnt", count, 0);
    check("t5_rst_ready", st_ready, 1);
    check("t5_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_post_req", mem_req, 0);
    end
    mem_ack = 1'b0;

    // 6: SW to misaligned address 0x101
    drive(1'b1, 32'h101, 32'hCAFEF00D, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
`ifdef MISALIGN_TRAP_EN
    check("t6_err_pulse", st_err, 1);
    check("t6_not_queued", count, 0);
    tick();
    check("t6_err_clear", st_err, 0);
    check("t6_no_req", mem_req, 0);
`else
    check("t6_err_zero", st_err, 0);
    check("t6_queued", count, 1);
    tick();
    check("t6_req", mem_req, 1);
    check("t6_addr", mem_addr, 32'h100);
    check("t6_be", mem_be, 4'b1111);
    check("t6_wdata", mem_wdata, 32'hCAFEF00D);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t6_done", mem_req, 0);
`endif

    // 7: simultaneous push and pop keeps count, next entry follows
    drive(1'b1, 32'h700, 32'h70, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    check("t7_req", mem_req, 1);
    mem_ack = 1'b1;
    drive(1'b1, 32'h705, 32'h000000C3, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    check("t7_cnt_same", count, 1);
    check("t7_next_req", mem_req, 1);
    check("t7_next_addr", mem_addr, 32'h704);
    check("t7_next_wdata", mem_wdata, 32'hC3C3C3C3);
    check("t7_next_be", mem_be, 4'b0010);
    tick();
    mem_ack = 1'b0;
    check("t7_end_req", mem_req, 0);
    check("t7_end_cnt", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
